// File: rtl/bip_uart_bridge_if.sv
// Signal bundle between the BIP/UART bridge and its UART RX/TX and BIP core neighbours.
// The slave side is the bridge; the master side is whatever drives the bridge inputs.
interface bip_uart_bridge_if #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = 11,
  parameter int RAM_WIDTH = 16
);
  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic [NB_OPCODE-1:0] i_opcode;
  logic [RAM_WIDTH-1:0] i_acc;
  logic [NB_ADDR-1:0]   i_pc;
  logic                 i_tx_done;
  logic                 o_tx_start;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_bip_en;
  logic                 o_busy;

  modport slave (
    input  i_rx_data, i_rx_done, i_opcode, i_acc, i_pc, i_tx_done,
    output o_tx_start, o_tx_data, o_bip_en, o_busy
  );

  modport master (
    output i_rx_data, i_rx_done, i_opcode, i_acc, i_pc, i_tx_done,
    input  o_tx_start, o_tx_data, o_bip_en, o_busy
  );
endinterface

// File: rtl/bip_uart_bridge.sv
// Starts the BIP on a UART start byte, counts its cycles until the halt opcode,
// then reports ACC, PC and cycle count over UART TX, each field LSB byte first.
module bip_uart_bridge #(
  parameter int                   NB_DATA     = 8,
  parameter int                   NB_OPCODE   = 5,
  parameter int                   NB_ADDR     = 11,
  parameter int                   RAM_WIDTH   = 16,
  parameter int                   NB_CYCLES   = 16,
  parameter logic [NB_DATA-1:0]   START_CMD   = 8'h53,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bip_uart_bridge_if.slave  bus
);

  localparam int NBY_ACC = (RAM_WIDTH + NB_DATA - 1) / NB_DATA;
  localparam int NBY_PC  = (NB_ADDR   + NB_DATA - 1) / NB_DATA;
  localparam int NBY_CYC = (NB_CYCLES + NB_DATA - 1) / NB_DATA;
  localparam int N_BYTES = NBY_ACC + NBY_PC + NBY_CYC;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int W_ACC   = NBY_ACC * NB_DATA;
  localparam int W_PC    = NBY_PC  * NB_DATA;
  localparam int W_CYC   = NBY_CYC * NB_DATA;
  localparam int W_FRAME = W_ACC + W_PC + W_CYC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10,
    ST_WAIT = 2'b11
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 rx_done_r;
  logic [NB_CYCLES-1:0] cyc_cnt_r, cyc_cnt_nxt_s, cyc_inc_s;
  logic [RAM_WIDTH-1:0] acc_snap_r, acc_snap_nxt_s;
  logic [NB_ADDR-1:0]   pc_snap_r, pc_snap_nxt_s;
  logic [NB_CYCLES-1:0] cyc_snap_r, cyc_snap_nxt_s;
  logic [NB_IDX-1:0]    idx_r, idx_nxt_s;
  logic                 tx_start_r;
  logic [NB_DATA-1:0]   tx_data_r;
  logic                 start_evt_s;
  logic [W_FRAME-1:0]   frame_s;
  logic [NB_DATA-1:0]   frame_bytes_s [N_BYTES];

  assign start_evt_s = bus.i_rx_done & ~rx_done_r & (bus.i_rx_data == START_CMD);
  assign cyc_inc_s   = (&cyc_cnt_r) ? cyc_cnt_r : cyc_cnt_r + NB_CYCLES'(1);

  // The frame is built from the next snapshot so byte 0 is ready on the halt cycle itself.
  assign frame_s = {W_CYC'(cyc_snap_nxt_s), W_PC'(pc_snap_nxt_s), W_ACC'(acc_snap_nxt_s)};

  for (genvar g = 0; g < N_BYTES; g++) begin : g_frame_byte
    assign frame_bytes_s[g] = frame_s[g*NB_DATA +: NB_DATA];
  end

  // Next-state, counter, snapshot and byte-index logic.
  always_comb begin
    state_nxt_s    = state_r;
    cyc_cnt_nxt_s  = cyc_cnt_r;
    acc_snap_nxt_s = acc_snap_r;
    pc_snap_nxt_s  = pc_snap_r;
    cyc_snap_nxt_s = cyc_snap_r;
    idx_nxt_s      = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start_evt_s) begin
          cyc_cnt_nxt_s = '0;
          state_nxt_s   = ST_RUN;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        cyc_cnt_nxt_s = cyc_inc_s;
        if (bus.i_opcode == HALT_OPCODE) begin
          acc_snap_nxt_s = bus.i_acc;
          pc_snap_nxt_s  = bus.i_pc;
          cyc_snap_nxt_s = cyc_inc_s;
          idx_nxt_s      = '0;
          state_nxt_s    = ST_LOAD;
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_r == NB_IDX'(N_BYTES - 1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            idx_nxt_s   = idx_r + NB_IDX'(1);
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        idx_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and registered TX outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      rx_done_r  <= 1'b0;
      cyc_cnt_r  <= '0;
      acc_snap_r <= '0;
      pc_snap_r  <= '0;
      cyc_snap_r <= '0;
      idx_r      <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rx_done_r  <= bus.i_rx_done;
      cyc_cnt_r  <= cyc_cnt_nxt_s;
      acc_snap_r <= acc_snap_nxt_s;
      pc_snap_r  <= pc_snap_nxt_s;
      cyc_snap_r <= cyc_snap_nxt_s;
      idx_r      <= idx_nxt_s;
      tx_start_r <= (state_nxt_s == ST_LOAD);
      if (state_nxt_s == ST_LOAD) begin
        tx_data_r <= frame_bytes_s[idx_nxt_s];
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign bus.o_tx_start = tx_start_r;
  assign bus.o_tx_data  = tx_data_r;
  assign bus.o_bip_en   = (state_r == ST_RUN);
  assign bus.o_busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bip_uart_bridge.sv
// Directed bench: three bridge configurations (defaults, 4-bit counter, 12-bit ACC / 8-bit PC)
// share one stimulus; a small TX model per instance acknowledges bytes and records them.
module tb_bip_uart_bridge;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [4:0]  opcode = OP_NOP;
  logic [15:0] acc = 16'h0000;
  logic [10:0] pc = 11'h000;

  logic        tx_start_s [3];
  logic [7:0]  tx_data_s  [3];
  logic        bip_en_s   [3];
  logic        busy_s     [3];
  logic        tx_done_r  [3];
  int          cd_r       [3];
  logic [7:0]  got_bytes_r [3][16];
  int          nbytes_r   [3];
  int          en_cnt_r   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bip_uart_bridge_if                                  if0 ();
  bip_uart_bridge_if                                  if1 ();
  bip_uart_bridge_if #(.RAM_WIDTH(12), .NB_ADDR(8))   if2 ();

  bip_uart_bridge                                     dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  bip_uart_bridge #(.NB_CYCLES(4))                    dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  bip_uart_bridge #(.RAM_WIDTH(12), .NB_ADDR(8))      dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  assign if0.i_rx_data = rx_data;  assign if1.i_rx_data = rx_data;  assign if2.i_rx_data = rx_data;
  assign if0.i_rx_done = rx_done;  assign if1.i_rx_done = rx_done;  assign if2.i_rx_done = rx_done;
  assign if0.i_opcode  = opcode;   assign if1.i_opcode  = opcode;   assign if2.i_opcode  = opcode;
  assign if0.i_acc     = acc;      assign if1.i_acc     = acc;      assign if2.i_acc     = acc[11:0];
  assign if0.i_pc      = pc;       assign if1.i_pc      = pc;       assign if2.i_pc      = pc[7:0];
  assign if0.i_tx_done = tx_done_r[0];
  assign if1.i_tx_done = tx_done_r[1];
  assign if2.i_tx_done = tx_done_r[2];

  assign tx_start_s[0] = if0.o_tx_start; assign tx_data_s[0] = if0.o_tx_data;
  assign tx_start_s[1] = if1.o_tx_start; assign tx_data_s[1] = if1.o_tx_data;
  assign tx_start_s[2] = if2.o_tx_start; assign tx_data_s[2] = if2.o_tx_data;
  assign bip_en_s[0] = if0.o_bip_en;     assign busy_s[0] = if0.o_busy;
  assign bip_en_s[1] = if1.o_bip_en;     assign busy_s[1] = if1.o_busy;
  assign bip_en_s[2] = if2.o_bip_en;     assign busy_s[2] = if2.o_busy;

  // TX model: done pulse three cycles after each start; records bytes and enabled cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      tx_done_r[k] <= 1'b0;
      if (rst) begin
        cd_r[k] <= 0;
      end else if (tx_start_s[k]) begin
        cd_r[k] <= 3;
      end else if (cd_r[k] != 0) begin
        cd_r[k] <= cd_r[k] - 1;
        if (cd_r[k] == 1) tx_done_r[k] <= 1'b1;
      end
      if (clr) begin
        nbytes_r[k] <= 0;
        en_cnt_r[k] <= 0;
      end else begin
        if (tx_start_s[k] && nbytes_r[k] < 16) begin
          got_bytes_r[k][nbytes_r[k]] <= tx_data_s[k];
          nbytes_r[k] <= nbytes_r[k] + 1;
        end
        if (bip_en_s[k]) en_cnt_r[k] <= en_cnt_r[k] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame_of(input int k);
    logic [63:0] p;
    p = 64'h0;
    for (int i = 0; i < nbytes_r[k] && i < 8; i++) p = p | (64'(got_bytes_r[k][i]) << (8 * i));
    return p;
  endfunction

  task automatic clear_log();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  // Called in RUN cycle 1; leaves the bench in the LOAD cycle of byte 0.
  task automatic run_halt(input int n);
    repeat (n - 1) step();
    opcode = OP_HALT;
    step();
    opcode = OP_NOP;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && (busy_s[0] | busy_s[1] | busy_s[2]); i++) step();
    check_eq("idle_timeout", 64'(busy_s[0] | busy_s[1] | busy_s[2]), 64'h0);
  endtask

  task automatic check_frames(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                              input logic [63:0] e2, input int n0, input int n1, input int n2,
                              input int en);
    check_eq({tag, "_n0"},    64'(nbytes_r[0]), 64'(n0));
    check_eq({tag, "_n1"},    64'(nbytes_r[1]), 64'(n1));
    check_eq({tag, "_n2"},    64'(nbytes_r[2]), 64'(n2));
    check_eq({tag, "_data0"}, frame_of(0), e0);
    check_eq({tag, "_data1"}, frame_of(1), e1);
    check_eq({tag, "_data2"}, frame_of(2), e2);
    check_eq({tag, "_en0"},   64'(en_cnt_r[0]), 64'(en));
    check_eq({tag, "_en2"},   64'(en_cnt_r[2]), 64'(en));
  endtask

  initial begin
    int i;
    // Reset state
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    check_eq("rst_tx_start", 64'(if0.o_tx_start), 64'h0);
    check_eq("rst_tx_data",  64'(if0.o_tx_data),  64'h0);
    check_eq("rst_bip_en",   64'(if0.o_bip_en),   64'h0);
    check_eq("rst_busy",     64'(if0.o_busy),     64'h0);
    rst = 1'b0;
    step();

    // Basic frame: halt on the 10th RUN cycle
    acc = 16'h1234;
    pc  = 11'h5A7;
    send(8'h53);
    check_eq("s1_bip_en_lat", 64'(if0.o_bip_en), 64'h1);
    run_halt(10);
    check_eq("s1_first_start", 64'(if0.o_tx_start), 64'h1);
    check_eq("s1_first_byte",  64'(if0.o_tx_data),  64'h34);
    check_eq("s1_frozen",      64'(if0.o_bip_en),   64'h0);
    step();
    check_eq("s1_wait_start",  64'(if0.o_tx_start), 64'h0);
    check_eq("s1_wait_hold",   64'(if0.o_tx_data),  64'h34);
    wait_idle();
    check_frames("s1", 64'h0000_000A_05A7_1234, 64'h0000_000A_05A7_1234,
                 64'h0000_0000_0AA7_0234, 6, 5, 5, 10);

    // Non-start byte and held-high rx_done are ignored
    clear_log();
    acc = 16'hBEEF;
    pc  = 11'h123;
    send(8'h41);
    step();
    rx_data = 8'h41;
    rx_done = 1'b1;
    step();
    rx_data = 8'h53;
    repeat (5) step();
    check_eq("s2_held_busy",  64'(if0.o_busy),   64'h0);
    check_eq("s2_held_bipen", 64'(if0.o_bip_en), 64'h0);
    rx_done = 1'b0;
    step();
    send(8'h53);
    check_eq("s2_start_bipen", 64'(if0.o_bip_en), 64'h1);

    // Halt on the first RUN cycle; inputs change during the report
    run_halt(1);
    step();
    acc = 16'hFFFF;
    pc  = 11'h000;
    wait_idle();
    check_frames("s3", 64'h0000_0001_0123_BEEF, 64'h0000_0001_0123_BEEF,
                 64'h0000_0000_0123_0EEF, 6, 5, 5, 1);

    // 20 RUN cycles: the 4-bit counter saturates at 0xF
    clear_log();
    acc = 16'h0ABC;
    pc  = 11'h03F;
    send(8'h53);
    run_halt(20);
    wait_idle();
    check_frames("s4", 64'h0000_0014_003F_0ABC, 64'h0000_000F_003F_0ABC,
                 64'h0000_0000_143F_0ABC, 6, 5, 5, 20);
    check_eq("s4_en1", 64'(en_cnt_r[1]), 64'd20);

    // Reset while waiting on byte 3 abandons the frame
    clear_log();
    send(8'h53);
    run_halt(1);
    for (i = 0; i < 200 && nbytes_r[0] != 4; i++) step();
    check_eq("s5_reach_byte3", 64'(nbytes_r[0]), 64'd4);
    rst = 1'b1;
    step();
    check_eq("s5_rst_busy",     64'(if0.o_busy),     64'h0);
    check_eq("s5_rst_tx_start", 64'(if0.o_tx_start), 64'h0);
    check_eq("s5_rst_bip_en",   64'(if0.o_bip_en),   64'h0);
    rst = 1'b0;
    repeat (12) step();
    check_eq("s5_no_more_bytes", 64'(nbytes_r[0]), 64'd4);
    clear_log();
    acc = 16'h1234;
    pc  = 11'h5A7;
    send(8'h53);
    check_eq("s5_restart_bipen", 64'(if0.o_bip_en), 64'h1);
    run_halt(2);
    wait_idle();
    check_eq("s5_restart_n",    64'(nbytes_r[0]), 64'd6);
    check_eq("s5_restart_data", frame_of(0), 64'h0000_0002_05A7_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
